// File: rtl/buzzer_tone_player_pkg.sv
// Shared types and constants for the buzzer tone player: FSM states, note
// code field positions and the octave-0 note frequencies.
package buzzer_tone_player_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int OCT_MSB = 7;
    localparam int OCT_LSB = 4;
    localparam int DEG_MSB = 3;
    localparam int DEG_LSB = 0;

    localparam int F_DO = 261;
    localparam int F_RE = 293;
    localparam int F_MI = 329;
    localparam int F_FA = 349;
    localparam int F_SO = 392;
    localparam int F_LA = 440;
    localparam int F_TI = 494;

    // Clock cycles per square-wave period at octave 0, truncated.
    function automatic int base_period(input int clk_fre, input int freq_hz);
        return (clk_fre * 1000000) / freq_hz;
    endfunction

endpackage

// File: rtl/buzzer_tone_player_note_rom.sv
// Combinational degree -> octave-0 base period lookup with a legal flag.
// Degree 0 is a legal rest with a zero period.
module buzzer_note_rom
    import buzzer_tone_player_pkg::*;
#(
    parameter int CLK_FRE = 50,
    parameter int CNT_W   = 20
) (
    input  logic [3:0]       degree_i,
    output logic [CNT_W-1:0] base_o,
    output logic             legal_o
);

    localparam logic [CNT_W-1:0] P_DO = CNT_W'(base_period(CLK_FRE, F_DO));
    localparam logic [CNT_W-1:0] P_RE = CNT_W'(base_period(CLK_FRE, F_RE));
    localparam logic [CNT_W-1:0] P_MI = CNT_W'(base_period(CLK_FRE, F_MI));
    localparam logic [CNT_W-1:0] P_FA = CNT_W'(base_period(CLK_FRE, F_FA));
    localparam logic [CNT_W-1:0] P_SO = CNT_W'(base_period(CLK_FRE, F_SO));
    localparam logic [CNT_W-1:0] P_LA = CNT_W'(base_period(CLK_FRE, F_LA));
    localparam logic [CNT_W-1:0] P_TI = CNT_W'(base_period(CLK_FRE, F_TI));

    always_comb begin
        base_o  = '0;
        legal_o = 1'b1;
        case (degree_i)
            4'd0:    base_o = '0;
            4'd1:    base_o = P_DO;
            4'd2:    base_o = P_RE;
            4'd3:    base_o = P_MI;
            4'd4:    base_o = P_FA;
            4'd5:    base_o = P_SO;
            4'd6:    base_o = P_LA;
            4'd7:    base_o = P_TI;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/buzzer_tone_player.sv
// Sequenced square-wave note player: one note per valid/ready handshake,
// played for dur_ms, followed by a fixed silent gap and a note_done pulse.
module buzzer_tone_player
    import buzzer_tone_player_pkg::*;
#(
    parameter int CLK_FRE = 50,
    parameter int CNT_W   = 20,
    parameter int NUM_OCT = 4,
    parameter int DUR_W   = 16,
    parameter int GAP_MS  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [7:0]       note_code,
    input  logic [DUR_W-1:0] note_dur_ms,
    input  logic             abort,
    output logic             buzzer_out,
    output logic             busy,
    output logic             note_done,
    output logic             bad_note
);

    localparam logic [CNT_W-1:0] MS_LAST  = CNT_W'(CLK_FRE * 1000 - 1);
    localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_MS - 1);

    state_t             state_q, state_d;
    logic [7:0]         code_q, code_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [CNT_W-1:0]   half_q, half_d;
    logic               tone_q, tone_d;
    logic [CNT_W-1:0]   pre_q, pre_d;
    logic [DUR_W-1:0]   ms_q, ms_d;
    logic [CNT_W-1:0]   hc_q, hc_d;
    logic               buzz_q, buzz_d;
    logic               done_q, done_d;

    logic [CNT_W-1:0]   rom_base;
    logic               rom_legal;
    logic               oct_ok;
    logic               code_ok;
    logic               ms_wrap;
    logic               hc_wrap;

    buzzer_note_rom #(
        .CLK_FRE (CLK_FRE),
        .CNT_W   (CNT_W)
    ) u_rom (
        .degree_i (code_q[DEG_MSB:DEG_LSB]),
        .base_o   (rom_base),
        .legal_o  (rom_legal)
    );

    assign oct_ok  = (int'(code_q[OCT_MSB:OCT_LSB]) < NUM_OCT);
    assign code_ok = rom_legal && oct_ok;
    assign ms_wrap = (pre_q == MS_LAST);
    assign hc_wrap = (hc_q == half_q - CNT_W'(1));

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        dur_d   = dur_q;
        half_d  = half_q;
        tone_d  = tone_q;
        pre_d   = pre_q;
        ms_d    = ms_q;
        hc_d    = hc_q;
        buzz_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (note_valid) begin
                    code_d  = note_code;
                    dur_d   = note_dur_ms;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                half_d = (rom_base >> code_q[OCT_MSB:OCT_LSB]) >> 1;
                tone_d = code_ok && (code_q[DEG_MSB:DEG_LSB] != 4'd0);
                pre_d  = '0;
                ms_d   = '0;
                hc_d   = '0;
                if (dur_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                pre_d  = ms_wrap ? '0 : pre_q + CNT_W'(1);
                hc_d   = hc_wrap ? '0 : hc_q + CNT_W'(1);
                buzz_d = tone_q && (hc_wrap ? !buzz_q : buzz_q);
                if (ms_wrap) begin
                    if (ms_q == dur_q - DUR_W'(1)) begin
                        state_d = GAP;
                        ms_d    = '0;
                        hc_d    = '0;
                        buzz_d  = 1'b0;
                    end else begin
                        ms_d = ms_q + DUR_W'(1);
                    end
                end
            end
            GAP: begin
                pre_d = ms_wrap ? '0 : pre_q + CNT_W'(1);
                if (ms_wrap) begin
                    if (ms_q == GAP_LAST) begin
                        state_d = IDLE;
                        ms_d    = '0;
                        done_d  = 1'b1;
                    end else begin
                        ms_d = ms_q + DUR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything except an idle player, which keeps accepting.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            pre_d   = '0;
            ms_d    = '0;
            hc_d    = '0;
            buzz_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= '0;
            dur_q   <= '0;
            half_q  <= '0;
            tone_q  <= 1'b0;
            pre_q   <= '0;
            ms_q    <= '0;
            hc_q    <= '0;
            buzz_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            dur_q   <= dur_d;
            half_q  <= half_d;
            tone_q  <= tone_d;
            pre_q   <= pre_d;
            ms_q    <= ms_d;
            hc_q    <= hc_d;
            buzz_q  <= buzz_d;
            done_q  <= done_d;
        end
    end

    assign note_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign buzzer_out = buzz_q;
    assign note_done  = done_q;
    assign bad_note   = (state_q == LOAD) && !code_ok;

endmodule
